// File: rtl/wptr_full_level.sv
// Write-side pointer and status generator for a dual-clock FIFO.
// Keeps the binary/Gray write pointers, drives the memory write port and
// derives full, almost-full, fill level and a sticky overflow flag from the
// read pointer after it has been synchronised into wclk.
module wptr_full_level #(
    parameter int ADDRSIZE = 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   afull_thresh,
    input  logic                clr_ovf,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wcount,
    output logic                wovf
);

    localparam int PW = ADDRSIZE + 1;

    // State registers and their next-state values
    logic [PW-1:0] wbin_q,   wbin_d;
    logic [PW-1:0] wgray_q,  wgray_d;
    logic          wfull_q,  wfull_d;
    logic          wafull_q, wafull_d;
    logic [PW-1:0] wcount_q, wcount_d;
    logic          wovf_q,   wovf_d;

    // Combinational intermediates
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] level;
    logic [PW-1:0] full_gray;

    // Gray-to-binary conversion of the synchronised read pointer
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rbin_s = '0;
        for (int i = 0; i < PW; i++) begin
            rbin_s[i] = ^(wq2_rptr >> i);
        end
    end

    // Next-state logic for pointers and status flags
    always_comb begin
        wen      = winc & ~wfull_q;
        wbin_d   = wbin_q + PW'(wen);
        wgray_d  = (wbin_d >> 1) ^ wbin_d;

        // Full when the next Gray pointer equals the read pointer with its top
        // two bits inverted: one full lap ahead of the reader.
        full_gray = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
        wfull_d   = (wgray_d == full_gray);

        level    = wbin_d - rbin_s;
        wcount_d = level;
        wafull_d = (afull_thresh != '0) && (level >= afull_thresh);

        // A write attempt while full sets the flag; set beats clear.
        wovf_d = wovf_q;
        if (winc && wfull_q) begin
            wovf_d = 1'b1;
        end else if (clr_ovf) begin
            wovf_d = 1'b0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wcount_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wcount_q <= wcount_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr  = wbin_q[ADDRSIZE-1:0];
    assign wptr   = wgray_q;
    assign wfull  = wfull_q;
    assign wafull = wafull_q;
    assign wcount = wcount_q;
    assign wovf   = wovf_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// Self-checking bench for wptr_full_level (ADDRSIZE=4): table-driven fill and
// overflow vectors, plus hand-written wrap, threshold-disable and mid-cycle
// reset sequences.
module tb_wptr_full_level;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic [4:0] afull_thresh;
    logic       clr_ovf;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       wafull;
    logic [4:0] wcount;
    logic       wovf;

    int tests_run = 0;
    int tests_failed = 0;

    wptr_full_level #(.ADDRSIZE(4)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .afull_thresh (afull_thresh),
        .clr_ovf      (clr_ovf),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .wafull       (wafull),
        .wcount       (wcount),
        .wovf         (wovf)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic       winc;
        logic [4:0] rptr;
        logic [4:0] thr;
        logic       clr;
        logic       exp_wen;
        logic       exp_wfull;
        logic       exp_wafull;
        logic [4:0] exp_wcount;
        logic       exp_wovf;
        logic [4:0] exp_wptr;
        logic [3:0] exp_waddr;
    } vec_t;

    vec_t vecs[22];

    function automatic logic [4:0] gray(input logic [4:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock: rising edge, then park on the falling edge for sampling.
    task automatic cycle();
        @(posedge wclk);
        @(negedge wclk);
    endtask

    task automatic do_reset();
        winc = 1'b0;
        clr_ovf = 1'b0;
        wq2_rptr = '0;
        afull_thresh = '0;
        wrst_n = 1'b0;
        cycle();
        cycle();
        wrst_n = 1'b1;
        cycle();
    endtask

    task automatic check_all(input string tag, input logic e_wfull, input logic e_wafull,
                             input logic [4:0] e_wcount, input logic e_wovf,
                             input logic [4:0] e_wptr, input logic [3:0] e_waddr);
        check({tag, ".wfull"},  int'(wfull),  int'(e_wfull));
        check({tag, ".wafull"}, int'(wafull), int'(e_wafull));
        check({tag, ".wcount"}, int'(wcount), int'(e_wcount));
        check({tag, ".wovf"},   int'(wovf),   int'(e_wovf));
        check({tag, ".wptr"},   int'(wptr),   int'(e_wptr));
        check({tag, ".waddr"},  int'(waddr),  int'(e_waddr));
    endtask

    initial begin
        logic [4:0] prev_ptr;
        logic [4:0] rb;

        // Fill rows: 16 writes against an idle reader, threshold 12.
        for (int k = 0; k < 16; k++) begin
            vecs[k] = '{1'b1, 5'd0, 5'd12, 1'b0,
                        1'b1, (k == 15), (k + 1 >= 12), 5'(k + 1), 1'b0,
                        gray(5'(k + 1)), 4'((k + 1) % 16)};
        end
        // Two write attempts while full set the sticky overflow.
        vecs[16] = '{1'b1, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1, 5'd16, 1'b1, 5'b11000, 4'd0};
        vecs[17] = '{1'b1, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1, 5'd16, 1'b1, 5'b11000, 4'd0};
        // Clear without a write attempt.
        vecs[18] = '{1'b0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 5'd16, 1'b0, 5'b11000, 4'd0};
        // Clear with a write attempt while full: set wins.
        vecs[19] = '{1'b1, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 5'd16, 1'b1, 5'b11000, 4'd0};
        // Reader advances to binary 4 (Gray 00110): level 12.
        vecs[20] = '{1'b0, 5'b00110, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 5'b11000, 4'd0};
        // Raise threshold to 13: almost-full drops.
        vecs[21] = '{1'b0, 5'b00110, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 5'b11000, 4'd0};

        // Reset state
        do_reset();
        check_all("reset", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 4'd0);
        check("reset.wen", int'(wen), 0);

        // Table-driven fill / overflow / drain
        for (int i = 0; i < 22; i++) begin
            winc = vecs[i].winc;
            wq2_rptr = vecs[i].rptr;
            afull_thresh = vecs[i].thr;
            clr_ovf = vecs[i].clr;
            #1;
            check($sformatf("vec%0d.wen", i), int'(wen), int'(vecs[i].exp_wen));
            cycle();
            check_all($sformatf("vec%0d", i), vecs[i].exp_wfull, vecs[i].exp_wafull,
                      vecs[i].exp_wcount, vecs[i].exp_wovf, vecs[i].exp_wptr, vecs[i].exp_waddr);
        end

        // Wrap: 34 writes with the reader trailing, ending at Gray(30)
        do_reset();
        clr_ovf = 1'b0;
        afull_thresh = 5'd0;
        prev_ptr = wptr;
        for (int k = 0; k < 34; k++) begin
            rb = (k < 3) ? 5'd0 : 5'(k - 3);
            wq2_rptr = gray(rb);
            winc = 1'b1;
            #1;
            check($sformatf("wrap%0d.wen", k), int'(wen), 1);
            cycle();
            check($sformatf("wrap%0d.onebit", k), $countones(prev_ptr ^ wptr), 1);
            prev_ptr = wptr;
            if (k == 31) check("wrap.ptr_zero_at_32", int'(wptr), 0);
        end
        winc = 1'b0;
        check("wrap.rptr_is_gray30", int'(wq2_rptr), int'(5'b10001));
        check("wrap.waddr", int'(waddr), 2);
        check("wrap.wcount", int'(wcount), 4);
        check("wrap.wfull", int'(wfull), 0);
        check("wrap.wptr", int'(wptr), int'(5'b00011));

        // Threshold 0 disables almost-full all the way to full
        do_reset();
        afull_thresh = 5'd0;
        winc = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cycle();
            check($sformatf("thr0_%0d.wafull", k), int'(wafull), 0);
        end
        check("thr0.wfull", int'(wfull), 1);
        check("thr0.wcount", int'(wcount), 16);

        // Mid-cycle asynchronous reset with wcount=7, wovf=1
        winc = 1'b1;
        cycle();                       // write attempt while full -> overflow
        winc = 1'b0;
        wq2_rptr = 5'b01101;           // Gray(9)
        cycle();
        check("pre_rst.wcount", int'(wcount), 7);
        check("pre_rst.wovf", int'(wovf), 1);
        #2;
        wrst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 4'd0);
        @(negedge wclk);
        wq2_rptr = '0;
        wrst_n = 1'b1;
        winc = 1'b1;
        #1;
        check("post_rst.waddr", int'(waddr), 0);
        check("post_rst.wen", int'(wen), 1);
        cycle();
        winc = 1'b0;
        check("post_rst.wptr", int'(wptr), 1);
        check("post_rst.waddr1", int'(waddr), 1);
        check("post_rst.wcount", int'(wcount), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wptr_full_level.md
Name: wptr_full_level

Overview:
- Write-side pointer and status generator for the dual-clock FIFO; the write-domain counterpart of the read pointer / empty logic.
- Keeps the binary and Gray write pointers and drives the memory write address and write enable.
- Compares against the read pointer after it has been synchronised into wclk, and produces the full, almost-full, fill-level and sticky overflow outputs.
- Sits between the write client, the FIFO memory and the read-to-write pointer synchroniser.

Parameters:
ADDRSIZE, 4, memory address width; FIFO depth is 2^ADDRSIZE; pointers are ADDRSIZE+1 bits wide.

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  asynchronous active-low reset.
- winc  input  1  write request from the client.
- wq2_rptr  input  ADDRSIZE+1  Gray-coded read pointer, already synchronised into wclk.
- afull_thresh  input  ADDRSIZE+1  almost-full threshold in entries; 0 disables almost-full.
- clr_ovf  input  1  clears the sticky overflow flag.
- wen  output  1  memory write enable (combinational).
- waddr  output  ADDRSIZE  memory write address.
- wptr  output  ADDRSIZE+1  registered Gray write pointer, sent to the write-to-read synchroniser.
- wfull  output  1  FIFO full (registered).
- wafull  output  1  FIFO almost full (registered).
- wcount  output  ADDRSIZE+1  fill level, 0..2^ADDRSIZE (registered).
- wovf  output  1  sticky overflow flag (registered).

Behaviour:
- Single clock wclk; wrst_n is asynchronous, active-low.
- Reset values, applied immediately on wrst_n low with no clock needed: wbin=0, wptr=0, wfull=0, wafull=0, wcount=0, wovf=0. waddr therefore reads 0.
- Write enable and address:
  - wen = winc & ~wfull.
  - waddr = wbin[ADDRSIZE-1:0].
  - A write is accepted on a wclk edge where wen=1.
- Pointer update:
  - wbinnext = wbin + wen, modulo 2^(ADDRSIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
  - On every edge, {wbin, wptr} <= {wbinnext, wgraynext}.
  - wptr changes by exactly one bit per accepted write.
- Read-pointer conversion: rbin_s[i] = XOR of wq2_rptr[ADDRSIZE:i] (Gray to binary, combinational).
- Full:
  - wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - wfull <= wfull_val, so wfull asserts on the same edge that accepts the last free entry.
- Fill level:
  - wcount <= wbinnext - rbin_s, modulo 2^(ADDRSIZE+1).
  - wcount = 2^ADDRSIZE exactly when wfull_val is true.
- Almost-full: wafull <= (afull_thresh != 0) && (wbinnext - rbin_s >= afull_thresh). A threshold above 2^ADDRSIZE never asserts.
- Overflow:
  - If winc & wfull on an edge, wovf <= 1 and the write is dropped; wbin, wptr and the memory are unchanged.
  - Otherwise clr_ovf=1 gives wovf <= 0.
  - Set has priority over clear when both occur on the same edge.
- Status is pessimistic:
  - wfull, wafull and wcount deassert or fall only after the read pointer has propagated through the synchroniser.
  - Writes never overrun the reader.
- Same-cycle events: a write on the edge where wq2_rptr advances uses the new wq2_rptr value for all status outputs.
- Wrap-around:
  - wbin wraps from 2^(ADDRSIZE+1)-1 to 0.
  - The extra MSB distinguishes full from empty, so status stays correct across the wrap.
- Reset mid-operation: all state returns to the reset values asynchronously; the first write after reset release targets waddr 0.
- Size: implementation is roughly 120-200 lines, including the Gray-to-binary loop and the status registers.

Test Plan (ADDRSIZE=4):
- Reset release with winc=0 → wfull=0, wafull=0, wcount=0, wptr=5'b00000, waddr=0, wovf=0, wen=0.
- wq2_rptr=0, afull_thresh=12, winc=1 for 16 edges:
  - after the 12th edge: wcount=12, wafull=1.
  - after the 16th edge: wfull=1, wcount=16, wptr=5'b11000, waddr=0.
- While full, winc=1 for 2 edges:
  - wen=0, wptr holds 5'b11000, wovf=1 after the first edge.
  - clr_ovf pulse with winc=0 → wovf=0.
  - clr_ovf=1 together with winc=1 while full → wovf stays 1.
- While full, drive wq2_rptr=5'b00110 (binary 4) → next edge: wfull=0, wcount=12, wafull=1; with afull_thresh=13 → wafull=0.
- Wrap: 34 accepted writes with wq2_rptr=Gray(30)=5'b10001 → wbin=2, waddr=2, wcount=4, wfull=0; wptr passed through 5'b00000 at write 32.
- afull_thresh=0, fill to full → wafull stays 0 throughout.
- Pull wrst_n low between clock edges with wcount=7, wovf=1 → all outputs reach reset values before the next wclk edge; after release, the first write goes to waddr=0.
